// File: rtl/polyvec_encode12_pkg.sv
// Shared ML-KEM types and constants for the ByteEncode_12 polyvec serialiser.
// Optional canonical reduction of coefficients is enabled by ENCODE_CANON_REDUCE_EN.
package polyvec_encode12_pkg;

   localparam int unsigned ML_KEM_K             = 2;
   localparam int unsigned ML_KEM_Q             = 3329;
   localparam int unsigned ML_KEM_LEN_Q         = 12;
   localparam int unsigned ML_KEM_N             = 256;
   localparam int unsigned ENC12_WORDS_PER_POLY = 48;
   localparam int unsigned ENC12_GROUP_W        = 192;
   localparam int unsigned ENC12_GROUP_COEFFS   = 16;

   typedef logic [ML_KEM_LEN_Q-1:0]          coeff_t;
   typedef coeff_t [ML_KEM_N-1:0]            poly_t;
   typedef poly_t [ML_KEM_K-1:0]             polyvec_t;
   typedef coeff_t [ENC12_GROUP_COEFFS-1:0]  group_t;

   typedef enum logic [1:0] {
      StIdle,
      StPrep,
      StSend,
      StDone
   } enc12_state_e;

endpackage

// File: rtl/polyvec_encode12_if.sv
// Control and stream bundle of the polyvec encoder; master is the encoder side,
// slave is the host/consumer side.
interface polyvec_encode12_if
   import polyvec_encode12_pkg::*;
#(
   parameter int unsigned NPOLY = ML_KEM_K
) ();

   logic               run_i;
   poly_t [NPOLY-1:0]  polyvec_i;
   logic [63:0]        word_o;
   logic               valid_o;
   logic               ready_i;
   logic               last_o;
   logic               busy_o;
   logic               done_o;

   modport master (
      input  run_i, polyvec_i, ready_i,
      output word_o, valid_o, last_o, busy_o, done_o
   );

   modport slave (
      output run_i, polyvec_i, ready_i,
      input  word_o, valid_o, last_o, busy_o, done_o
   );

endinterface

// File: rtl/polyvec_encode12_coeff_cond_sub.sv
// Sixteen parallel conditional subtractors mapping [0, 2q-1] onto [0, q-1].
// Only compiled when ENCODE_CANON_REDUCE_EN is defined.
`ifdef ENCODE_CANON_REDUCE_EN
module polyvec_encode12_coeff_cond_sub
   import polyvec_encode12_pkg::*;
(
   input  group_t i_coeff,
   output group_t o_coeff
);

   localparam coeff_t Q = coeff_t'(ML_KEM_Q);

   always_comb begin
      for (int i = 0; i < int'(ENC12_GROUP_COEFFS); i++) begin
         o_coeff[i] = (i_coeff[i] >= Q) ? i_coeff[i] - Q : i_coeff[i];
      end
   end

endmodule
`endif

// File: rtl/polyvec_encode12.sv
// ML-KEM ByteEncode_12 serialiser: NPOLY x 256 12-bit coefficients -> 64-bit stream beats.
// ENCODE_CANON_REDUCE_EN adds conditional reduction mod q in the group load path.
module polyvec_encode12
   import polyvec_encode12_pkg::*;
#(
   parameter int unsigned NPOLY = ML_KEM_K
) (
   input logic                clk_i,
   input logic                rst_i,
   polyvec_encode12_if.master io_bus
);

   localparam int unsigned    PolyW    = (NPOLY > 1) ? $clog2(NPOLY) : 1;
   localparam logic [PolyW-1:0] LastPoly = PolyW'(NPOLY - 1);

   enc12_state_e               r_state, w_state_nxt;
   poly_t [NPOLY-1:0]          r_vec;
   logic [ENC12_GROUP_W-1:0]   r_group;
   logic [1:0]                 r_beat, w_beat_nxt;
   logic [3:0]                 r_grp, w_grp_nxt;
   logic [PolyW-1:0]           r_poly, w_poly_nxt;

   logic                       w_cap_en;
   logic                       w_ld_en;
   logic [3:0]                 w_ld_grp;
   logic [PolyW-1:0]           w_ld_poly;
   group_t                     w_ld_raw;
   group_t                     w_ld_coeffs;

   logic                       w_beat_last;
   logic                       w_grp_last;
   logic                       w_poly_last;

   assign w_beat_last = (r_beat == 2'd2);
   assign w_grp_last  = (r_grp == 4'd15);
   assign w_poly_last = (r_poly == LastPoly);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_vec   <= '0;
         r_group <= '0;
         r_beat  <= '0;
         r_grp   <= '0;
         r_poly  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_grp   <= w_grp_nxt;
         r_poly  <= w_poly_nxt;
         if (w_cap_en) r_vec   <= io_bus.polyvec_i;
         if (w_ld_en)  r_group <= w_ld_coeffs;
      end
   end

   // The capture edge is IDLE->PREP; PREP loads group 0 so the first beat is valid two cycles
   // after run_i. On the final beat of a group the next group loads at the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_grp_nxt   = r_grp;
      w_poly_nxt  = r_poly;
      w_cap_en    = 1'b0;
      w_ld_en     = 1'b0;
      w_ld_grp    = r_grp;
      w_ld_poly   = r_poly;
      unique case (r_state)
         StIdle: begin
            if (io_bus.run_i) begin
               w_cap_en    = 1'b1;
               w_state_nxt = StPrep;
               w_beat_nxt  = '0;
               w_grp_nxt   = '0;
               w_poly_nxt  = '0;
            end
         end
         StPrep: begin
            w_ld_en     = 1'b1;
            w_ld_grp    = '0;
            w_ld_poly   = '0;
            w_state_nxt = StSend;
         end
         StSend: begin
            if (io_bus.ready_i) begin
               if (!w_beat_last) begin
                  w_beat_nxt = r_beat + 2'd1;
               end else begin
                  w_beat_nxt = '0;
                  if (w_grp_last && w_poly_last) begin
                     w_state_nxt = StDone;
                  end else begin
                     w_ld_en = 1'b1;
                     if (w_grp_last) begin
                        w_grp_nxt  = '0;
                        w_poly_nxt = r_poly + 1'b1;
                     end else begin
                        w_grp_nxt  = r_grp + 4'd1;
                     end
                     w_ld_grp  = w_grp_nxt;
                     w_ld_poly = w_poly_nxt;
                  end
               end
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
            w_grp_nxt   = '0;
            w_poly_nxt  = '0;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      for (int i = 0; i < int'(ENC12_GROUP_COEFFS); i++) begin
         w_ld_raw[i] = r_vec[w_ld_poly][{w_ld_grp, 4'(i)}];
      end
   end

`ifdef ENCODE_CANON_REDUCE_EN
   polyvec_encode12_coeff_cond_sub u_reduce (
      .i_coeff (w_ld_raw),
      .o_coeff (w_ld_coeffs)
   );
`else
   assign w_ld_coeffs = w_ld_raw;
`endif

   assign io_bus.word_o  = r_group[{r_beat, 6'd0} +: 64];
   assign io_bus.valid_o = (r_state == StSend);
   assign io_bus.last_o  = (r_state == StSend) && w_beat_last && w_grp_last && w_poly_last;
   assign io_bus.busy_o  = (r_state == StPrep) || (r_state == StSend);
   assign io_bus.done_o  = (r_state == StDone);

endmodule

// File: tb/tb_polyvec_encode12.sv
// Directed bench for polyvec_encode12 with NPOLY=2; expectations from hand constants
// and a flat bit-slice model of the input vector.
module tb_polyvec_encode12;
   import polyvec_encode12_pkg::*;

   localparam int unsigned NP     = 2;
   localparam int          NBEATS = ENC12_WORDS_PER_POLY * NP;

   logic clk = 1'b0;
   logic rst = 1'b1;

   polyvec_encode12_if #(.NPOLY(NP)) bus ();

   polyvec_encode12 #(.NPOLY(NP)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] got [NBEATS];
   int          got_n;
   polyvec_t    v_ones, v_ramp, v_alt, v_red;
   logic [63:0] exp0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the PREP cycle.
   task automatic start_run(input polyvec_t v);
      bus.polyvec_i = v;
      bus.run_i     = 1'b1;
      @(negedge clk);
      bus.run_i     = 1'b0;
   endtask

   // mode 0: ready held high; mode 1: 1,0,0,1 pattern then random.
   task automatic collect(input int mode, input int start, input int stop);
      logic        stalled;
      logic [63:0] hold_w;
      logic        hold_l;
      logic        rdy;
      logic [3:0]  pat;
      pat     = 4'b1001;
      stalled = 1'b0;
      hold_w  = '0;
      hold_l  = 1'b0;
      got_n   = start;
      for (int c = 0; c < 3000 && got_n < stop; c++) begin
         if (stalled) begin
            check("stall_valid", 64'(bus.valid_o), 64'd1);
            check("stall_word", bus.word_o, hold_w);
            check("stall_last", 64'(bus.last_o), 64'(hold_l));
         end
         if (mode == 0)    rdy = 1'b1;
         else if (c < 16)  rdy = pat[c % 4];
         else              rdy = 1'($urandom_range(0, 1));
         bus.ready_i = rdy;
         if (bus.valid_o && rdy) begin
            got[got_n] = bus.word_o;
            check("last_flag", 64'(bus.last_o), 64'(got_n == NBEATS - 1));
            got_n++;
         end
         stalled = bus.valid_o && !rdy;
         hold_w  = bus.word_o;
         hold_l  = bus.last_o;
         @(negedge clk);
      end
      check("beat_count", 64'(got_n), 64'(stop));
   endtask

   // At the negedge after the final transfer.
   task automatic check_done();
      check("done_pulse", 64'(bus.done_o), 64'd1);
      check("done_busy", 64'(bus.busy_o), 64'd0);
      check("done_valid", 64'(bus.valid_o), 64'd0);
      @(negedge clk);
      check("done_clear", 64'(bus.done_o), 64'd0);
   endtask

   task automatic check_stream(input string tag, input polyvec_t v);
      logic [NP*3072-1:0] flat;
      flat = v;
      for (int k = 0; k < NBEATS; k++) begin
         check(tag, got[k], flat[64*k +: 64]);
      end
   endtask

   initial begin
      bus.run_i     = 1'b0;
      bus.ready_i   = 1'b0;
      bus.polyvec_i = '0;
      v_red         = '0;
      for (int p = 0; p < int'(NP); p++) begin
         for (int n = 0; n < 256; n++) begin
            v_ones[p][n] = 12'h001;
            v_ramp[p][n] = (p == 0) ? 12'(n) : 12'((n * 7 + 5) % 3329);
            v_alt[p][n]  = 12'(3328 - n - 256 * p);
         end
      end
      v_red[0][0] = 12'hD01;
      v_red[0][1] = 12'hD02;
      v_red[0][2] = 12'hD00;

      repeat (3) @(negedge clk);
      check("rst_valid", 64'(bus.valid_o), 64'd0);
      check("rst_busy", 64'(bus.busy_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      check("rst_last", 64'(bus.last_o), 64'd0);
      check("rst_word", bus.word_o, 64'd0);
      rst = 1'b0;
      bus.ready_i = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready_valid", 64'(bus.valid_o), 64'd0);
      check("idle_ready_busy", 64'(bus.busy_o), 64'd0);

      // 1: all-ones stream, ready held
      start_run(v_ones);
      collect(0, 0, NBEATS);
      check_done();
      check("ones_w0", got[0], 64'h1001001001001001);
      check("ones_w1", got[1], 64'h0100100100100100);
      check("ones_w2", got[2], 64'h0010010010010010);
      check("ones_w95", got[95], 64'h0010010010010010);
      check_stream("ones_stream", v_ones);

      // 2: latency and first word of a ramp
      @(negedge clk);
      bus.polyvec_i = v_ramp;
      bus.run_i     = 1'b1;
      @(negedge clk);
      bus.run_i     = 1'b0;
      check("lat_t1_valid", 64'(bus.valid_o), 64'd0);
      check("lat_t1_busy", 64'(bus.busy_o), 64'd1);
      @(negedge clk);
      check("lat_t2_valid", 64'(bus.valid_o), 64'd1);
      check("ramp_w0", bus.word_o, 64'h5004003002001000);
      collect(0, 0, NBEATS);
      check_done();
      check_stream("ramp_stream", v_ramp);

      // 3: back-pressure
      start_run(v_ones);
      collect(1, 0, NBEATS);
      check_done();
      check_stream("stall_stream", v_ones);

      // 4: reset mid-stream, then a clean run
      bus.ready_i = 1'b1;
      start_run(v_ramp);
      collect(0, 0, 20);
      rst = 1'b1;
      #1;
      check("abort_valid", 64'(bus.valid_o), 64'd0);
      check("abort_busy", 64'(bus.busy_o), 64'd0);
      check("abort_last", 64'(bus.last_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_done", 64'(bus.done_o), 64'd0);
      end
      start_run(v_alt);
      collect(0, 0, NBEATS);
      check_done();
      check_stream("after_abort_stream", v_alt);

      // 5: run_i during streaming is ignored
      start_run(v_ramp);
      collect(0, 0, 10);
      bus.ready_i   = 1'b0;
      bus.polyvec_i = v_alt;
      bus.run_i     = 1'b1;
      @(negedge clk);
      bus.run_i     = 1'b0;
      check("rerun_busy", 64'(bus.busy_o), 64'd1);
      collect(0, 10, NBEATS);
      check_done();
      check_stream("rerun_stream", v_ramp);

      // 6: values at and above q
`ifdef ENCODE_CANON_REDUCE_EN
      exp0 = 64'h0000_000D_0000_1000;
`else
      exp0 = 64'h0000_000D_00D0_2D01;
`endif
      start_run(v_red);
      collect(0, 0, NBEATS);
      check_done();
      check("reduce_w0", got[0], exp0);
      check("reduce_w1", got[1], 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
